multicycle_controller: RTL

Control unit for the multicycle MIPS datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles on one shared ALU and one shared instruction/data memory. It replaces the single-cycle main decoder plus ALU decoder pair. It drives every datapath mux select and write enable, waits on a memory-ready handshake, and traps unsupported instructions in a sticky error state.

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback on a shared ALU and memory, with a MemReady handshake and sticky trap.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       Error,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_ERROR    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_NONE  = 2'd3;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_st;
  logic [1:0] w_aluop;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
      default:                                               funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] f);
    case (op)
      ALUOP_ADD: alu_decode = 3'b010;
      ALUOP_SUB: alu_decode = 3'b110;
      ALUOP_FUNCT: begin
        case (f)
          6'b100000: alu_decode = 3'b010;
          6'b100010: alu_decode = 3'b110;
          6'b100100: alu_decode = 3'b000;
          6'b100101: alu_decode = 3'b001;
          6'b101010: alu_decode = 3'b111;
          default:   alu_decode = 3'b000;
        endcase
      end
      default: alu_decode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:    w_next = funct_legal(Funct) ? S_EXECUTE : S_ERROR;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:      w_next = S_BRANCH;
          OP_ADDI:     w_next = S_ADDIEX;
          OP_J:        w_next = S_JUMP;
          default:     w_next = S_ERROR;
        endcase
      end
      S_MEMADR:   w_next = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ADDIEX:   w_next = S_ADDIWB;
      S_ADDIWB:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_FETCH;
    endcase
  end

  // While reset_n is low the outputs look like FETCH, with every strobe held off below.
  assign w_st = reset_n ? r_state : S_FETCH;

  always_comb begin
    w_aluop    = ALUOP_NONE;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    case (w_st)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_aluop   = ALUOP_ADD;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        w_aluop = ALUOP_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_aluop = ALUOP_ADD;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = ALUOP_SUB;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_aluop = ALUOP_ADD;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn       = reset_n & (w_pcwrite | (w_branch & Zero));
  assign MemWrite   = reset_n & w_memwrite;
  assign IRWrite    = reset_n & w_irwrite;
  assign RegWrite   = reset_n & w_regwrite;
  assign ALUControl = alu_decode(w_aluop, Funct);
  assign Error      = (w_st == S_ERROR);
  assign State      = r_state;

endmodule
